// File: rtl/return_address_stack.sv
// Checkpointed return address stack for the fetch stage.
// Circular 32-bit stack with a FIFO of pointer snapshots for flush recovery.
module return_address_stack #(
    parameter int ENTRIES     = 8,
    parameter int CHECKPOINTS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] new_addr,
    input  logic        branch_fetched,
    input  logic        branch_retired,
    input  logic        fetch_flush,
    output logic [31:0] addr,
    output logic        ckpt_full,
    output logic        ckpt_lost
);
    localparam int TW = $clog2(ENTRIES);
    localparam int CW = $clog2(CHECKPOINTS) + 1;
    localparam int IW = CW - 1;

    logic [31:0]   stack [ENTRIES];
    logic [TW-1:0] ckpt  [CHECKPOINTS];

    logic [TW-1:0] top;
    logic [TW-1:0] top_inc;
    logic [TW-1:0] top_dec;
    logic [TW-1:0] top_nxt;
    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          lost;
    logic          empty;
    logic          full;
    logic          deq;
    logic          enq;
    logic          drop;

    assign top_inc = top + TW'(1);
    assign top_dec = top - TW'(1);

    always_comb begin
        top_nxt = top;
        if (push && !pop) begin
            top_nxt = top_inc;
        end else if (pop && !push) begin
            top_nxt = top_dec;
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (count == CW'(CHECKPOINTS));
    // A same-cycle retire frees the slot the new snapshot needs.
    assign deq   = branch_retired && !empty;
    assign enq   = branch_fetched && (!full || deq);
    assign drop  = branch_fetched && full && !deq;

    assign addr      = stack[top];
    assign ckpt_full = full;
    assign ckpt_lost = lost;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                stack[i] <= '0;
            end
        end else if (!fetch_flush) begin
            if (push && !pop) begin
                stack[top_inc] <= new_addr;
            end else if (push && pop) begin
                stack[top] <= new_addr;
            end
        end
    end

    // Snapshot holds the pointer as it will be after this cycle's push/pop.
    always_ff @(posedge clk) begin
        if (enq && !fetch_flush) begin
            ckpt[wr_ptr[IW-1:0]] <= top_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            top    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            lost   <= 1'b0;
        end else if (fetch_flush) begin
            if (!empty && !lost) begin
                top <= ckpt[rd_ptr[IW-1:0]];
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            lost   <= 1'b0;
        end else begin
            top <= top_nxt;
            if (enq) begin
                wr_ptr <= wr_ptr + CW'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + CW'(1);
            end
            if (enq && !deq) begin
                count <= count + CW'(1);
            end else if (deq && !enq) begin
                count <= count - CW'(1);
            end
            if (drop) begin
                lost <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_return_address_stack.sv
// Scoreboard bench for return_address_stack: directed strobes queue
// hand-computed expectations, a monitor pops and compares after each edge.
module tb_return_address_stack;

    logic        clk;
    logic        rst;
    logic        push;
    logic        pop;
    logic [31:0] new_addr;
    logic        branch_fetched;
    logic        branch_retired;
    logic        fetch_flush;
    logic [31:0] addr;
    logic        ckpt_full;
    logic        ckpt_lost;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic        f;
        logic        l;
    } exp_t;

    exp_t exp_q[$];
    event chk_ev;
    int   n_vec;
    int   n_bad;

    return_address_stack #(
        .ENTRIES    (8),
        .CHECKPOINTS(4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .push          (push),
        .pop           (pop),
        .new_addr      (new_addr),
        .branch_fetched(branch_fetched),
        .branch_retired(branch_retired),
        .fetch_flush   (fetch_flush),
        .addr          (addr),
        .ckpt_full     (ckpt_full),
        .ckpt_lost     (ckpt_lost)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always begin
        exp_t e;
        @(posedge clk or chk_ev);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (addr !== e.a || ckpt_full !== e.f || ckpt_lost !== e.l) begin
                n_bad++;
                $display("FAIL %s: got addr=%h full=%b lost=%b, want addr=%h full=%b lost=%b",
                         e.name, addr, ckpt_full, ckpt_lost, e.a, e.f, e.l);
            end
        end
    end

    task automatic step(input string name, input logic ps, input logic pp,
                        input logic [31:0] na, input logic bf, input logic br,
                        input logic ff, input logic [31:0] ea,
                        input logic ef, input logic el);
        exp_t e;
        @(negedge clk);
        push           = ps;
        pop            = pp;
        new_addr       = na;
        branch_fetched = bf;
        branch_retired = br;
        fetch_flush    = ff;
        e.name = name;
        e.a    = ea;
        e.f    = ef;
        e.l    = el;
        exp_q.push_back(e);
    endtask

    // Reset asserted between edges, checked before any clock edge.
    task automatic areset(input string name);
        exp_t e;
        @(negedge clk);
        push           = 1'b0;
        pop            = 1'b0;
        new_addr       = '0;
        branch_fetched = 1'b0;
        branch_retired = 1'b0;
        fetch_flush    = 1'b0;
        rst            = 1'b0;
        e.name = name;
        e.a    = 32'h0;
        e.f    = 1'b0;
        e.l    = 1'b0;
        exp_q.push_back(e);
        ->chk_ev;
        #2;
        rst = 1'b1;
    endtask

    initial begin
        logic [31:0] v;
        n_vec          = 0;
        n_bad          = 0;
        rst            = 1'b0;
        push           = 1'b0;
        pop            = 1'b0;
        new_addr       = '0;
        branch_fetched = 1'b0;
        branch_retired = 1'b0;
        fetch_flush    = 1'b0;
        areset("reset");

        step("push100", 1, 0, 32'h100, 0, 0, 0, 32'h100, 0, 0);
        step("push200", 1, 0, 32'h200, 0, 0, 0, 32'h200, 0, 0);
        step("push300", 1, 0, 32'h300, 0, 0, 0, 32'h300, 0, 0);
        step("pop1",    0, 1, 32'h0,   0, 0, 0, 32'h200, 0, 0);
        step("pop2",    0, 1, 32'h0,   0, 0, 0, 32'h100, 0, 0);

        step("push200b", 1, 0, 32'h200, 0, 0, 0, 32'h200, 0, 0);
        step("tailcall", 1, 1, 32'h500, 0, 0, 0, 32'h500, 0, 0);
        step("below",    0, 1, 32'h0,   0, 0, 0, 32'h100, 0, 0);

        for (int k = 1; k <= 9; k++) begin
            v = 32'(k * 16);
            step($sformatf("ovf_push%0d", k), 1, 0, v, 0, 0, 0, v, 0, 0);
        end
        for (int k = 8; k >= 2; k--) begin
            v = 32'(k * 16);
            step($sformatf("ovf_pop%0h", v), 0, 1, 32'h0, 0, 0, 0, v, 0, 0);
        end
        step("ovf_wrap", 0, 1, 32'h0, 0, 0, 0, 32'h90, 0, 0);

        step("pushA0",    1, 0, 32'hA0, 0, 0, 0, 32'hA0, 0, 0);
        step("snapA0",    0, 0, 32'h0,  1, 0, 0, 32'hA0, 0, 0);
        step("pushB0",    1, 0, 32'hB0, 0, 0, 0, 32'hB0, 0, 0);
        step("pushC0",    1, 0, 32'hC0, 0, 0, 0, 32'hC0, 0, 0);
        step("flush_rst", 0, 0, 32'h0,  0, 0, 1, 32'hA0, 0, 0);
        step("ret_empty", 0, 0, 32'h0,  0, 1, 0, 32'hA0, 0, 0);
        step("pushD0",    1, 0, 32'hD0, 0, 0, 0, 32'hD0, 0, 0);
        step("flush_hold",0, 0, 32'h0,  0, 0, 1, 32'hD0, 0, 0);

        step("bf1", 0, 0, 32'h0, 1, 0, 0, 32'hD0, 0, 0);
        step("bf2", 0, 0, 32'h0, 1, 0, 0, 32'hD0, 0, 0);
        step("bf3", 0, 0, 32'h0, 1, 0, 0, 32'hD0, 0, 0);
        step("bf4", 0, 0, 32'h0, 1, 0, 0, 32'hD0, 1, 0);
        step("bf5", 0, 0, 32'h0, 1, 0, 0, 32'hD0, 1, 1);
        step("pushE0",      1, 0, 32'hE0, 0, 0, 0, 32'hE0, 1, 1);
        step("flush_lost",  0, 0, 32'h0,  0, 0, 1, 32'hE0, 0, 0);
        step("bf6", 0, 0, 32'h0, 1, 0, 0, 32'hE0, 0, 0);
        step("bf7", 0, 0, 32'h0, 1, 0, 0, 32'hE0, 0, 0);
        step("bf8", 0, 0, 32'h0, 1, 0, 0, 32'hE0, 0, 0);
        step("bf9", 0, 0, 32'h0, 1, 0, 0, 32'hE0, 1, 0);
        step("bf_br_full",  0, 0, 32'h0,  1, 1, 0, 32'hE0, 1, 0);
        step("flush_rest",  0, 0, 32'h0,  0, 0, 1, 32'hE0, 0, 0);

        step("snap_push",   1, 0, 32'hF0,  1, 0, 0, 32'hF0,  0, 0);
        step("push111",     1, 0, 32'h111, 0, 0, 0, 32'h111, 0, 0);
        step("flush_post",  0, 0, 32'h0,   0, 0, 1, 32'hF0,  0, 0);
        step("flush_prio",  1, 0, 32'h222, 1, 0, 1, 32'hF0,  0, 0);
        step("flush_tail",  1, 1, 32'h333, 0, 0, 1, 32'hF0,  0, 0);

        step("push31",      1, 0, 32'h31, 0, 0, 0, 32'h31, 0, 0);
        step("push32_bf",   1, 0, 32'h32, 1, 0, 0, 32'h32, 0, 0);
        step("push33_bf",   1, 0, 32'h33, 1, 0, 0, 32'h33, 0, 0);
        areset("async_rst");
        step("push44",      1, 0, 32'h44, 0, 0, 0, 32'h44, 0, 0);
        step("pop_cleared", 0, 1, 32'h0,  0, 0, 0, 32'h0,  0, 0);

        @(negedge clk);
        push           = 1'b0;
        pop            = 1'b0;
        branch_fetched = 1'b0;
        branch_retired = 1'b0;
        fetch_flush    = 1'b0;
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
